// File: rtl/rf_bank_arbiter.sv
// Operand-read scheduler for the 4-bank RF: per-bank request FIFOs, CDB writes pre-empt reads.
// Latency: a request accepted at edge N issues no earlier than cycle N+1; OC tag valid one cycle after issue.
// Backpressure: Stall_Arb_RAU rejects the whole dispatch if any targeted FIFO lacks room (registered count only).
module rf_bank_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROW_W      = 3,
  parameter int OCID_W     = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                Dispatch_Valid,
  input  logic                Src1_Valid,
  input  logic [1:0]          Src1_Bank,
  input  logic [ROW_W-1:0]    Src1_Row,
  input  logic [OCID_W-1:0]   Src1_OCID,
  input  logic                Src2_Valid,
  input  logic [1:0]          Src2_Bank,
  input  logic [ROW_W-1:0]    Src2_Row,
  input  logic [OCID_W-1:0]   Src2_OCID,
  output logic                Stall_Arb_RAU,
  input  logic                WriteValid,
  input  logic [1:0]          WriteBank,
  input  logic [ROW_W-1:0]    WriteRow,
  output logic [3:0]          RF_RdEn,
  output logic [4*ROW_W-1:0]  RF_RdRow,
  output logic [3:0]          RF_WrEn,
  output logic [4*ROW_W-1:0]  RF_WrRow,
  output logic [3:0]          OC_DataValid,
  output logic [4*OCID_W-1:0] OC_OCID,
  output logic [3:0]          Bank_Empty,
  output logic                Idle
);

  localparam int NB    = 4;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [OCID_W-1:0] ocid;
  } entry_t;

  entry_t           mem    [NB][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NB];
  logic [PTR_W-1:0] rd_ptr [NB];
  logic [CNT_W-1:0] count  [NB];

  logic [NB-1:0]    hit1;
  logic [NB-1:0]    hit2;
  logic [1:0]       need   [NB];
  logic [1:0]       push_n [NB];
  logic             stall;
  logic             accept;
  logic [NB-1:0]    rd_en;
  logic [NB-1:0]    bank_empty;
  entry_t           head   [NB];

  // Per-bank demand of this dispatch and the all-or-nothing room check.
  always_comb begin
    stall = 1'b0;
    for (int b = 0; b < NB; b++) begin
      hit1[b] = Dispatch_Valid & Src1_Valid & (Src1_Bank == 2'(b));
      hit2[b] = Dispatch_Valid & Src2_Valid & (Src2_Bank == 2'(b));
      need[b] = {1'b0, hit1[b]} + {1'b0, hit2[b]};
      if (CNT_W'(need[b]) > (CNT_W'(FIFO_DEPTH) - count[b])) begin
        stall = 1'b1;
      end
    end
    accept = Dispatch_Valid & ~stall;
    for (int b = 0; b < NB; b++) begin
      push_n[b] = accept ? need[b] : 2'd0;
    end
  end

  // Write port decode and read issue: a CDB write to a bank takes its port and blocks the pop.
  always_comb begin
    RF_WrRow = {NB{WriteRow}};
    RF_RdRow = '0;
    for (int b = 0; b < NB; b++) begin
      RF_WrEn[b]    = WriteValid & (WriteBank == 2'(b));
      bank_empty[b] = (count[b] == '0);
      head[b]       = mem[b][rd_ptr[b]];
      rd_en[b]      = ~bank_empty[b] & ~RF_WrEn[b];
      RF_RdRow[b*ROW_W +: ROW_W] = head[b].row;
    end
  end

  // FIFO pointer and occupancy bookkeeping; simultaneous push and pop on one bank are allowed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NB; b++) begin
        wr_ptr[b] <= '0;
        rd_ptr[b] <= '0;
        count[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        wr_ptr[b] <= wr_ptr[b] + PTR_W'(push_n[b]);
        if (rd_en[b]) begin
          rd_ptr[b] <= rd_ptr[b] + PTR_W'(1);
        end
        count[b] <= count[b] + CNT_W'(push_n[b]) - CNT_W'(rd_en[b]);
      end
    end
  end

  // FIFO storage; src1 lands first so a same-bank pair keeps src1 ahead of src2.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (accept && hit1[b]) begin
        mem[b][wr_ptr[b]] <= '{row: Src1_Row, ocid: Src1_OCID};
      end
      if (accept && hit2[b]) begin
        mem[b][wr_ptr[b] + PTR_W'(hit1[b])] <= '{row: Src2_Row, ocid: Src2_OCID};
      end
    end
  end

  // Tag return aligned to the one-cycle RF read latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      OC_DataValid <= '0;
      OC_OCID      <= '0;
    end else begin
      OC_DataValid <= rd_en;
      for (int b = 0; b < NB; b++) begin
        OC_OCID[b*OCID_W +: OCID_W] <= rd_en[b] ? head[b].ocid : '0;
      end
    end
  end

  assign RF_RdEn       = rd_en;
  assign Stall_Arb_RAU = stall;
  assign Bank_Empty    = bank_empty;
  assign Idle          = (&bank_empty) & ~(|OC_DataValid);

  // A pop from an empty FIFO would corrupt the occupancy count.
  generate
    for (genvar g = 0; g < NB; g++) begin : g_chk
      a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        rd_en[g] |-> (count[g] != '0));
      a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        count[g] <= CNT_W'(FIFO_DEPTH));
    end
  endgenerate

endmodule

// File: tb/tb_rf_bank_arbiter.sv
// Bench for rf_bank_arbiter: directed scenarios plus random traffic against a queue-based model.
// Model checks every cycle at the falling edge; inputs change 1 ns after the rising edge.
// Literal checks pin latency, ordering, write priority, stall and pointer wrap.
module tb_rf_bank_arbiter;

  localparam int FD = 4;
  localparam int RW = 3;
  localparam int OW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          Dispatch_Valid = 1'b0;
  logic          Src1_Valid = 1'b0, Src2_Valid = 1'b0;
  logic [1:0]    Src1_Bank = '0, Src2_Bank = '0;
  logic [RW-1:0] Src1_Row = '0, Src2_Row = '0;
  logic [OW-1:0] Src1_OCID = '0, Src2_OCID = '0;
  logic          Stall_Arb_RAU;
  logic          WriteValid = 1'b0;
  logic [1:0]    WriteBank = '0;
  logic [RW-1:0] WriteRow = '0;
  logic [3:0]    RF_RdEn, RF_WrEn, OC_DataValid, Bank_Empty;
  logic [4*RW-1:0] RF_RdRow, RF_WrRow;
  logic [4*OW-1:0] OC_OCID;
  logic          Idle;

  rf_bank_arbiter #(.FIFO_DEPTH(FD), .ROW_W(RW), .OCID_W(OW)) dut (
    .clk(clk), .rst(rst),
    .Dispatch_Valid(Dispatch_Valid),
    .Src1_Valid(Src1_Valid), .Src1_Bank(Src1_Bank), .Src1_Row(Src1_Row), .Src1_OCID(Src1_OCID),
    .Src2_Valid(Src2_Valid), .Src2_Bank(Src2_Bank), .Src2_Row(Src2_Row), .Src2_OCID(Src2_OCID),
    .Stall_Arb_RAU(Stall_Arb_RAU),
    .WriteValid(WriteValid), .WriteBank(WriteBank), .WriteRow(WriteRow),
    .RF_RdEn(RF_RdEn), .RF_RdRow(RF_RdRow), .RF_WrEn(RF_WrEn), .RF_WrRow(RF_WrRow),
    .OC_DataValid(OC_DataValid), .OC_OCID(OC_OCID),
    .Bank_Empty(Bank_Empty), .Idle(Idle)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int row;
    int ocid;
  } ent_t;

  ent_t q [4][$];
  logic [3:0] p_vld = '0;
  int         p_tag [4];

  // Compare the DUT with the model every cycle, then advance the model across the next rising edge.
  always @(negedge clk) begin
    int   need;
    logic e_stall;
    logic [3:0] e_rd, e_wr;
    logic [4*RW-1:0] e_wrrow;
    logic all_empty;
    ent_t e;
    if (!rst) begin
      chk("rst_ocv",   32'(OC_DataValid), 0);
      chk("rst_empty", 32'(Bank_Empty), 'hF);
      chk("rst_idle",  32'(Idle), 1);
      chk("rst_rden",  32'(RF_RdEn), 0);
      for (int b = 0; b < 4; b++) q[b].delete();
      p_vld = '0;
    end else begin
      e_stall = 1'b0;
      all_empty = 1'b1;
      for (int b = 0; b < 4; b++) begin
        need = ((Dispatch_Valid && Src1_Valid && Src1_Bank == 2'(b)) ? 1 : 0)
             + ((Dispatch_Valid && Src2_Valid && Src2_Bank == 2'(b)) ? 1 : 0);
        if (need > FD - q[b].size()) e_stall = 1'b1;
        e_wr[b] = WriteValid && (WriteBank == 2'(b));
        e_rd[b] = (q[b].size() > 0) && !e_wr[b];
        e_wrrow[b*RW +: RW] = WriteRow;
        if (q[b].size() > 0) all_empty = 1'b0;
      end
      chk("stall", 32'(Stall_Arb_RAU), 32'(e_stall));
      chk("rden",  32'(RF_RdEn), 32'(e_rd));
      chk("wren",  32'(RF_WrEn), 32'(e_wr));
      chk("wrrow", 32'(RF_WrRow), 32'(e_wrrow));
      chk("ocv",   32'(OC_DataValid), 32'(p_vld));
      for (int b = 0; b < 4; b++) begin
        if (e_rd[b]) chk("rdrow", 32'(RF_RdRow[b*RW +: RW]), 32'(q[b][0].row));
        if (p_vld[b]) chk("ocid", 32'(OC_OCID[b*OW +: OW]), 32'(p_tag[b]));
        chk("empty", 32'(Bank_Empty[b]), 32'(q[b].size() == 0));
      end
      chk("idle", 32'(Idle), 32'(all_empty && (p_vld == 4'd0)));
      // advance: pops first, then the accepted dispatch
      for (int b = 0; b < 4; b++) begin
        if (e_rd[b]) begin
          p_tag[b] = q[b][0].ocid;
          void'(q[b].pop_front());
        end
      end
      p_vld = e_rd;
      if (Dispatch_Valid && !e_stall) begin
        if (Src1_Valid) begin
          e.row = int'(Src1_Row); e.ocid = int'(Src1_OCID);
          q[Src1_Bank].push_back(e);
        end
        if (Src2_Valid) begin
          e.row = int'(Src2_Row); e.ocid = int'(Src2_OCID);
          q[Src2_Bank].push_back(e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic set_src(input logic dv,
                         input logic v1, input logic [1:0] b1, input logic [RW-1:0] r1, input logic [OW-1:0] o1,
                         input logic v2, input logic [1:0] b2, input logic [RW-1:0] r2, input logic [OW-1:0] o2);
    Dispatch_Valid = dv;
    Src1_Valid = v1; Src1_Bank = b1; Src1_Row = r1; Src1_OCID = o1;
    Src2_Valid = v2; Src2_Bank = b2; Src2_Row = r2; Src2_OCID = o2;
  endtask

  task automatic idle_src();
    set_src(1'b0, 1'b0, 2'd0, '0, '0, 1'b0, 2'd0, '0, '0);
  endtask

  task automatic set_wr(input logic v, input logic [1:0] b, input logic [RW-1:0] r);
    WriteValid = v; WriteBank = b; WriteRow = r;
  endtask

  initial begin
    int cnt;
    int got [$];

    // reset and release
    repeat (3) step();
    rst = 1'b1;
    look();
    chk("rel_rden", 32'(RF_RdEn), 0);
    chk("rel_idle", 32'(Idle), 1);

    // different banks
    step();
    set_src(1'b1, 1'b1, 2'd0, 3'd3, 3'd0, 1'b1, 2'd2, 3'd5, 3'd1);
    look();
    chk("db_stall", 32'(Stall_Arb_RAU), 0);
    step(); idle_src();
    look();
    chk("db_rden", 32'(RF_RdEn), 'b0101);
    chk("db_row0", 32'(RF_RdRow[0 +: RW]), 3);
    chk("db_row2", 32'(RF_RdRow[2*RW +: RW]), 5);
    step();
    look();
    chk("db_ocv",  32'(OC_DataValid), 'b0101);
    chk("db_tag0", 32'(OC_OCID[0 +: OW]), 0);
    chk("db_tag2", 32'(OC_OCID[2*OW +: OW]), 1);

    // same-bank pair
    step();
    set_src(1'b1, 1'b1, 2'd1, 3'd2, 3'd4, 1'b1, 2'd1, 3'd6, 3'd5);
    step(); idle_src();
    look();
    chk("sb_rd1", 32'(RF_RdEn[1]), 1);
    chk("sb_row_a", 32'(RF_RdRow[RW +: RW]), 2);
    step();
    look();
    chk("sb_row_b", 32'(RF_RdRow[RW +: RW]), 6);
    chk("sb_tag_a", 32'(OC_OCID[OW +: OW]), 4);
    step();
    look();
    chk("sb_ocv_b", 32'(OC_DataValid[1]), 1);
    chk("sb_tag_b", 32'(OC_OCID[OW +: OW]), 5);
    chk("sb_rd_done", 32'(RF_RdEn[1]), 0);

    // write priority on bank3
    step();
    set_src(1'b1, 1'b1, 2'd3, 3'd7, 3'd2, 1'b0, 2'd0, 3'd0, 3'd0);
    step(); idle_src(); set_wr(1'b1, 2'd3, 3'd1);
    for (int i = 0; i < 3; i++) begin
      look();
      chk("wp_rden3", 32'(RF_RdEn[3]), 0);
      chk("wp_wren3", 32'(RF_WrEn[3]), 1);
      step();
    end
    set_wr(1'b0, 2'd0, 3'd0);
    look();
    chk("wp_issue", 32'(RF_RdEn[3]), 1);
    chk("wp_row",   32'(RF_RdRow[3*RW +: RW]), 7);

    // full / stall on bank0 with pops blocked
    step(); set_wr(1'b1, 2'd0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      set_src(1'b1, 1'b1, 2'd0, 3'(i), 3'(i), 1'b0, 2'd0, 3'd0, 3'd0);
      step();
    end
    set_src(1'b1, 1'b1, 2'd0, 3'd4, 3'd4, 1'b1, 2'd0, 3'd5, 3'd5);
    look();
    chk("fs_pair_stall", 32'(Stall_Arb_RAU), 1);
    step();
    set_src(1'b1, 1'b1, 2'd0, 3'd6, 3'd6, 1'b0, 2'd0, 3'd0, 3'd0);
    look();
    chk("fs_single_ok", 32'(Stall_Arb_RAU), 0);
    step();
    set_src(1'b1, 1'b0, 2'd0, 3'd0, 3'd0, 1'b1, 2'd0, 3'd7, 3'd7);
    look();
    chk("fs_full_stall", 32'(Stall_Arb_RAU), 1);
    step(); idle_src(); set_wr(1'b0, 2'd0, 3'd0);
    cnt = 0;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      look();
      if (OC_DataValid[0]) begin
        cnt++;
        got.push_back(int'(OC_OCID[0 +: OW]));
      end
    end
    chk("fs_drain_cnt", 32'(cnt), 4);
    if (got.size() == 4) chk("fs_drain_last", 32'(got[3]), 6);

    // wrap-around on bank2
    got.delete();
    for (int i = 0; i < 14; i++) begin
      step();
      if (i < 10) set_src(1'b1, 1'b1, 2'd2, 3'(i % 8), 3'(i % 8), 1'b0, 2'd0, 3'd0, 3'd0);
      else idle_src();
      look();
      if (OC_DataValid[2]) got.push_back(int'(OC_OCID[2*OW +: OW]));
    end
    chk("wr_count", 32'(got.size()), 10);
    for (int i = 0; i < got.size() && i < 10; i++) chk("wr_order", 32'(got[i]), 32'(i % 8));

    // asynchronous reset mid-cycle with queued work
    step(); set_wr(1'b1, 2'd1, 3'd0);
    set_src(1'b1, 1'b1, 2'd1, 3'd1, 3'd1, 1'b1, 2'd1, 3'd2, 3'd2);
    step(); idle_src();
    step();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("ar_ocv",   32'(OC_DataValid), 0);
    chk("ar_empty", 32'(Bank_Empty), 'hF);
    chk("ar_idle",  32'(Idle), 1);
    chk("ar_stall", 32'(Stall_Arb_RAU), 0);
    step(); rst = 1'b1; set_wr(1'b0, 2'd0, 3'd0);
    look();
    chk("ar_rel_rden", 32'(RF_RdEn), 0);

    // random traffic, checked by the model process
    for (int i = 0; i < 3000; i++) begin
      step();
      set_src($urandom_range(3) != 0,
              $urandom_range(1) == 1, 2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)),
              $urandom_range(1) == 1, 2'($urandom_range(3)), 3'($urandom_range(7)), 3'($urandom_range(7)));
      set_wr($urandom_range(9) < 3, 2'($urandom_range(3)), 3'($urandom_range(7)));
    end
    step(); idle_src(); set_wr(1'b0, 2'd0, 3'd0);
    repeat (12) step();
    look();
    chk("end_idle", 32'(Idle), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/rf_bank_arbiter.md
Name: rf_bank_arbiter

Overview:
- Schedules accesses to the 4-bank operand register file and sits between the mapping stage and the RF banks.
- Takes up to two physical-operand read requests per dispatch (src1/src2, already mapped to bank/row with an OC tag) and queues them in per-bank request FIFOs.
- Each cycle, per bank, it issues one read from the FIFO head unless the CDB write to that bank takes the port (writes always win).
- It returns the OC tag alongside the 1-cycle RF read latency, so operand collectors can capture the data.

Parameters:
- FIFO_DEPTH, 4, entries per bank request FIFO (power of 2, >=2)
- ROW_W, 3, physical row address width
- OCID_W, 3, operand-collector slot tag width ({oc_id, src_sel})

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- Dispatch_Valid  in  1  qualifies the src request fields this cycle
- Src1_Valid  in  1  src1 read needed
- Src1_Bank  in  2  src1 physical bank
- Src1_Row  in  ROW_W  src1 physical row
- Src1_OCID  in  OCID_W  src1 destination OC slot
- Src2_Valid, Src2_Bank, Src2_Row, Src2_OCID  in  1/2/ROW_W/OCID_W  same as src1, for src2
- Stall_Arb_RAU  out  1  dispatch cannot be accepted this cycle
- WriteValid  in  1  CDB writeback this cycle (no backpressure)
- WriteBank  in  2  writeback bank
- WriteRow  in  ROW_W  writeback row
- RF_RdEn  out  4  per-bank read enable
- RF_RdRow  out  4*ROW_W  per-bank read row, bank b at [b*ROW_W +: ROW_W]
- RF_WrEn  out  4  per-bank write enable
- RF_WrRow  out  4*ROW_W  per-bank write row
- OC_DataValid  out  4  per-bank: RF read data valid this cycle
- OC_OCID  out  4*OCID_W  per-bank tag for OC_DataValid
- Bank_Empty  out  4  per-bank FIFO empty
- Idle  out  1  all FIFOs empty and no OC_DataValid pending

Behaviour:
- Reset (rst low, asynchronous): all FIFO pointers and counts are 0, all OC_DataValid and OC_OCID are 0, Bank_Empty=4'b1111, Idle=1. RF_RdEn is 0 because the FIFOs are empty. The FIFO contents are not reset. Reset mid-operation drops all queued requests.
- Per-bank demand: need[b] = Dispatch_Valid & Src1_Valid & (Src1_Bank==b) + Dispatch_Valid & Src2_Valid & (Src2_Bank==b), giving 0..2.
- Stall_Arb_RAU is combinational: 1 if any bank has need[b] > FIFO_DEPTH - count[b].
  - The check uses registered count only; no credit is given for a same-cycle pop.
- Accept = Dispatch_Valid & ~Stall_Arb_RAU. Acceptance is all-or-nothing: when stalled, neither src is enqueued.
- Enqueue on accept: entry {row, ocid} is pushed into the FIFO of its bank.
  - If src1 and src2 target the same bank, src1 is written at wr_ptr and src2 at wr_ptr+1, and count increases by 2.
  - Pointers wrap modulo FIFO_DEPTH.
- Write port, combinational: RF_WrEn[b] = WriteValid & (WriteBank==b), and RF_WrRow[b] = WriteRow.
- Read issue, combinational from registered FIFO state and the write inputs:
  - RF_RdEn[b] = ~Bank_Empty[b] & ~RF_WrEn[b]
  - RF_RdRow[b] = head row
- Pop: the head is popped at the clock edge when RF_RdEn[b]=1.
  - A push and a pop to the same bank in the same cycle are legal: count changes by need-1.
- Write conflict: a bank that is written holds its head (no pop) and retries next cycle. Other banks are unaffected.
- Latency:
  - An entry accepted at edge N is visible at the head no earlier than cycle N+1.
  - Its read is issued in the first cycle at or after that in which it is at the head and the bank is not written.
  - OC_DataValid[b] and OC_OCID[b] are registered, equal to RF_RdEn[b] and the head tag, one cycle after issue.
  - Each bank gives at most one read per cycle, so 4 reads per cycle in total.
- Ordering: strictly FIFO per bank. Across banks there is no ordering guarantee.
- Count is ROW-independent, range 0..FIFO_DEPTH. Overflow is impossible by construction; any underflow is an assertion failure.
- Bank_Empty[b] = (count[b]==0).
- Idle = &Bank_Empty & ~|OC_DataValid.

Test Plan:
- Reset then idle:
  - rst low asynchronously mid-cycle -> OC_DataValid=0, Bank_Empty=1111, Idle=1, Stall=0 immediately.
  - Release rst -> no RF_RdEn.
- Different banks:
  - Dispatch src1 (bank0,row3,ocid0) and src2 (bank2,row5,ocid1) at edge N.
  - Cycle N+1 -> RF_RdEn=0101, rows 3/5.
  - Cycle N+2 -> OC_DataValid=0101, OC_OCID tags 0/1.
- Same-bank pair:
  - src1 (bank1,row2,ocid4) and src2 (bank1,row6,ocid5).
  - Bank1 reads row2 at N+1 and row6 at N+2.
  - OC_OCID[1] = 4 then 5 at N+2 and N+3.
- Write priority:
  - Queue a bank3 read, then hold WriteValid with bank3 for 3 cycles.
  - RF_RdEn[3]=0 and RF_WrEn[3]=1 for those cycles; the read issues on the 4th cycle with the same row.
- Full/stall:
  - Fill bank0 to 3 entries while holding a bank0 write to block pops.
  - Dispatch a same-bank pair to bank0 -> Stall=1, and neither entry is enqueued (count stays 3).
  - A single bank0 src -> accepted, count=4.
  - A further bank0 dispatch -> stalled.
- Wrap-around:
  - Push 10 sequential single requests to bank2, tags 0..7 then 0..1, with no write blocking.
  - OC_OCID[2] order exactly matches push order across pointer wrap; no drops.
